// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and defaults for the shift-add multiplier controller
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADD   = 3'd2,
        SHIFT = 3'd3,
        DONE  = 3'd4
    } ctrl_state_t;

    localparam int N_BITS_DEF = 8;

endpackage

// File: rtl/multiplier_control_if.sv
// rtl/multiplier_control_if.sv - request/strobe bundle between controller and datapath
interface multiplier_control_if;

    logic Run;
    logic ClearA_LoadB;
    logic M;
    logic Clear_En;
    logic Load;
    logic Add_En;
    logic Sub_En;
    logic Shift_En;
    logic Busy;
    logic Done;

    // Requester/datapath side: drives requests and M, observes strobes
    modport master (
        output Run, ClearA_LoadB, M,
        input  Clear_En, Load, Add_En, Sub_En, Shift_En, Busy, Done
    );

    // Controller side
    modport slave (
        input  Run, ClearA_LoadB, M,
        output Clear_En, Load, Add_En, Sub_En, Shift_En, Busy, Done
    );

endinterface

// File: rtl/multiplier_control_iter_counter.sv
// rtl/multiplier_control_iter_counter.sv - iteration counter with terminal-count flag
module iter_counter #(
    parameter int N_BITS = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

    logic [CW-1:0] count_q;

    // Clear wins over increment; the controller never increments past LAST
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            count_q <= '0;
        end else if (inc_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign tc_o = (count_q == LAST);

endmodule

// File: rtl/multiplier_control.sv
// rtl/multiplier_control.sv - control FSM driving the shift-add multiplier datapath strobes
module multiplier_control
    import mult_pkg::*;
#(
    parameter int N_BITS = N_BITS_DEF
) (
    input  logic                 Clk,
    input  logic                 Reset,
    multiplier_control_if.slave  bus
);

    ctrl_state_t state_q, state_d;
    logic        cnt_clr;
    logic        cnt_inc;
    logic        cnt_tc;

    iter_counter #(.N_BITS(N_BITS)) u_iter_counter (
        .clk_i (Clk),
        .rst_i (Reset),
        .clr_i (cnt_clr),
        .inc_i (cnt_inc),
        .tc_o  (cnt_tc)
    );

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and strobe decode; Reset forces every output low in its own cycle
    always_comb begin
        state_d      = state_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;
        bus.Clear_En = 1'b0;
        bus.Load     = 1'b0;
        bus.Add_En   = 1'b0;
        bus.Sub_En   = 1'b0;
        bus.Shift_En = 1'b0;
        bus.Busy     = 1'b0;
        bus.Done     = 1'b0;
        if (!Reset) begin
            case (state_q)
                IDLE: begin
                    // Run takes priority so a start never coincides with a load
                    if (bus.Run) begin
                        state_d = CLEAR;
                    end else if (bus.ClearA_LoadB) begin
                        bus.Load     = 1'b1;
                        bus.Clear_En = 1'b1;
                    end
                end
                CLEAR: begin
                    bus.Clear_En = 1'b1;
                    bus.Busy     = 1'b1;
                    cnt_clr      = 1'b1;
                    state_d      = ADD;
                end
                ADD: begin
                    bus.Busy = 1'b1;
                    // Last iteration weighs the sign bit, hence subtract
                    bus.Add_En = bus.M && !cnt_tc;
                    bus.Sub_En = bus.M && cnt_tc;
                    state_d    = SHIFT;
                end
                SHIFT: begin
                    bus.Busy     = 1'b1;
                    bus.Shift_En = 1'b1;
                    if (cnt_tc) begin
                        cnt_clr = 1'b1;
                        state_d = DONE;
                    end else begin
                        cnt_inc = 1'b1;
                        state_d = ADD;
                    end
                end
                DONE: begin
                    bus.Done = 1'b1;
                    if (!bus.Run) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_control.sv
// tb/tb_multiplier_control.sv - directed self-checking bench for multiplier_control
module tb_multiplier_control;

    logic clk;
    logic rst;
    logic m_drv;
    logic use_dp;
    int   n_chk;
    int   n_bad;

    logic [7:0] dp_a;
    logic [7:0] dp_b;
    logic       dp_x;
    logic [7:0] dp_d;

    multiplier_control_if bus ();

    multiplier_control #(.N_BITS(8)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    // {Clear_En, Load, Add_En, Sub_En, Shift_En, Busy, Done}
    logic [6:0] obs;
    assign obs = {bus.Clear_En, bus.Load, bus.Add_En, bus.Sub_En,
                  bus.Shift_En, bus.Busy, bus.Done};

    assign bus.M = use_dp ? dp_b[0] : m_drv;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference datapath: X:A accumulator, B multiplier, D as both load value and S
    always @(posedge clk) begin
        if (bus.Load) dp_b <= dp_d;
        if (bus.Clear_En) begin
            dp_a <= 8'h00;
            dp_x <= 1'b0;
        end
        if (bus.Add_En) {dp_x, dp_a} <= {dp_a[7], dp_a} + {dp_d[7], dp_d};
        if (bus.Sub_En) {dp_x, dp_a} <= {dp_a[7], dp_a} - {dp_d[7], dp_d};
        if (bus.Shift_En) {dp_a, dp_b} <= {dp_x, dp_a, dp_b[7:1]};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Starts a multiply from IDLE with Run held for `hold` cycles and checks every cycle
    task automatic do_pass(input string name, input logic m, input int hold);
        int n_add;
        int n_sub;
        int n_sh;
        int last;
        int j;
        logic [6:0] e;
        n_add = 0;
        n_sub = 0;
        n_sh  = 0;
        m_drv   = m;
        bus.Run = 1'b1;
        #1;
        chk($sformatf("%s idle", name), 32'(obs), 32'h0);
        last = ((hold > 18) ? hold : 18) + 1;
        for (int c = 1; c <= last; c++) begin
            @(posedge clk);
            #1;
            if (c >= hold) bus.Run = 1'b0;
            #1;
            if (c == 1) begin
                e = 7'b1000010;
            end else if (c <= 17) begin
                j = c - 1;
                if (j % 2 == 1) e = {2'b00, m && (j < 15), m && (j == 15), 3'b010};
                else            e = 7'b0000110;
            end else if (c == 18 || (c - 1) < hold) begin
                e = 7'b0000001;
            end else begin
                e = 7'b0000000;
            end
            chk($sformatf("%s c%0d", name, c), 32'(obs), 32'(e));
            n_add += int'(bus.Add_En);
            n_sub += int'(bus.Sub_En);
            n_sh  += int'(bus.Shift_En);
        end
        chk($sformatf("%s n_add", name), 32'(n_add), m ? 32'd7 : 32'd0);
        chk($sformatf("%s n_sub", name), 32'(n_sub), m ? 32'd1 : 32'd0);
        chk($sformatf("%s n_shift", name), 32'(n_sh), 32'd8);
    endtask

    initial begin
        int waited;
        n_chk  = 0;
        n_bad  = 0;
        use_dp = 1'b0;
        m_drv  = 1'b0;
        dp_d   = 8'h00;
        rst    = 1'b1;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;

        // Reset for two cycles, then IDLE with everything low
        repeat (2) begin
            @(posedge clk);
            #2;
            chk("reset outs", 32'(obs), 32'h0);
        end
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("idle after reset", 32'(obs), 32'h0);

        // Clear/load in IDLE for one cycle
        bus.ClearA_LoadB = 1'b1;
        #1;
        chk("cl_lb strobes", 32'(obs), 32'b1100000);
        @(posedge clk);
        #1;
        bus.ClearA_LoadB = 1'b0;
        #1;
        chk("cl_lb drop", 32'(obs), 32'h0);
        @(posedge clk);
        #2;
        chk("still idle", 32'(obs), 32'h0);

        // Run beats ClearA_LoadB in the same IDLE cycle
        bus.ClearA_LoadB = 1'b1;
        bus.Run          = 1'b1;
        #1;
        chk("run prio", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        bus.Run          = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        #1;
        chk("run prio clear", 32'(obs), 32'b1000010);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #2;
        chk("idle again", 32'(obs), 32'h0);

        do_pass("m1", 1'b1, 1);
        do_pass("m0", 1'b0, 1);
        do_pass("hold40", 1'b1, 40);

        // Reset in the third SHIFT cycle
        m_drv   = 1'b1;
        bus.Run = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            bus.Run = 1'b0;
        end
        #1;
        chk("pre-reset shift", 32'(obs), 32'b0000110);
        rst = 1'b1;
        #1;
        chk("reset cycle outs", 32'(obs), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("post-reset idle", 32'(obs), 32'h0);
        do_pass("after_rst", 1'b1, 1);

        // Full multiply with the reference datapath: 7 * -5
        use_dp = 1'b1;
        dp_d   = 8'h07;
        bus.ClearA_LoadB = 1'b1;
        @(posedge clk);
        #1;
        bus.ClearA_LoadB = 1'b0;
        dp_d    = 8'hFB;
        bus.Run = 1'b1;
        @(posedge clk);
        #1;
        bus.Run = 1'b0;
        waited = 1;
        while (!bus.Done && waited < 40) begin
            @(posedge clk);
            #1;
            waited++;
        end
        chk("dp done latency", 32'(waited), 32'd18);
        chk("dp X", 32'(dp_x), 32'h1);
        chk("dp A:B", 32'({dp_a, dp_b}), 32'hFFDD);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
